// File: rtl/ring_token_arbiter_if.sv
// Client-side bundle for ring_token_arbiter.
// Requests and release go in; grant, token and status come out.
interface ring_token_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req_i;
  logic         release_i;
  logic [N-1:0] grant_o;
  logic [N-1:0] token_o;
  logic         busy_o;
  logic         timeout_o;

  modport master (
    output req_i,
    output release_i,
    input  grant_o,
    input  token_o,
    input  busy_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    input  release_i,
    output grant_o,
    output token_o,
    output busy_o,
    output timeout_o
  );
endinterface

// File: rtl/ring_token_arbiter.sv
// Round-robin arbiter with a one-hot token ring and a per-owner hold limit.
// IDLE picks the first requester at or above the token, GRANT holds, GAP idles one cycle.
module ring_token_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input logic                 clk,
  input logic                 reset,
  ring_token_arbiter_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  token_q, token_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [IW-1:0] tok_idx;
  logic [IW-1:0] own_idx;
  logic [N-1:0]  pick;
  logic          found;
  logic          end_norm;
  logic          at_limit;

  always_comb begin
    tok_idx = '0;
    own_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (token_q[i]) tok_idx = IW'(i);
      if (grant_q[i]) own_idx = IW'(i);
    end
  end

  // Circular scan from the token position, wrapping N-1 -> 0.
  always_comb begin
    logic [IW:0] j;
    pick  = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, tok_idx} + (IW+1)'(i);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      if (!found && |(bus.req_i & (N'(1) << j))) begin
        pick  = N'(1) << j;
        found = 1'b1;
      end
    end
  end

  assign end_norm = bus.release_i || !bus.req_i[own_idx];
  assign at_limit = (hold_q == HW'(MAX_HOLD));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    token_d   = token_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          state_d = GRANT;
          grant_d = pick;
          busy_d  = 1'b1;
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (end_norm || at_limit) begin
          state_d   = GAP;
          grant_d   = '0;
          busy_d    = 1'b0;
          hold_d    = '0;
          token_d   = {grant_q[N-2:0], grant_q[N-1]};
          timeout_d = !end_norm;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      token_q   <= N'(1);
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      token_q   <= token_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.grant_o   = grant_q;
  assign bus.token_o   = token_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = timeout_q;
endmodule

// File: tb/tb_ring_token_arbiter.sv
// Bench for ring_token_arbiter: vector table, hand sequences, random vs model.
// All expectations come from the table or the behavioural model below.
module tb_ring_token_arbiter;
  localparam int N    = 4;
  localparam int MAXH = 8;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  ring_token_arbiter_if #(.N(N)) bus ();

  ring_token_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         rel;
    logic [N-1:0] g;
    logic [N-1:0] t;
    logic         b;
    logic         to;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: owner as an index, phase 0 idle / 1 grant / 2 gap.
  int m_owner;
  int m_phase;
  int m_tok;
  int m_hold;
  int m_to;

  task automatic add(input logic r, input logic [N-1:0] q, input logic l,
                     input logic [N-1:0] g, input logic [N-1:0] t,
                     input logic b, input logic to);
    vec_t v;
    v.rst = r; v.req = q; v.rel = l;
    v.g = g; v.t = t; v.b = b; v.to = to;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] q, input logic l);
    reset         = r;
    bus.req_i     = q;
    bus.release_i = l;
    @(posedge clk);
    #1;
    chk("grant_onehot0", 32'($onehot0(bus.grant_o)), 32'd1);
    chk("token_onehot", 32'($onehot(bus.token_o)), 32'd1);
  endtask

  task automatic outs(input string tag, input logic [N-1:0] g,
                      input logic [N-1:0] t, input logic b, input logic to);
    chk({tag, ".grant"}, 32'(bus.grant_o), 32'(g));
    chk({tag, ".token"}, 32'(bus.token_o), 32'(t));
    chk({tag, ".busy"}, 32'(bus.busy_o), 32'(b));
    chk({tag, ".timeout"}, 32'(bus.timeout_o), 32'(to));
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] q,
                            input logic l);
    if (r) begin
      m_owner = -1; m_phase = 0; m_tok = 0; m_hold = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_phase == 0) begin
        if (q != 0) begin
          for (int i = N - 1; i >= 0; i--)
            if (q[(m_tok + i) % N]) m_owner = (m_tok + i) % N;
          m_phase = 1;
          m_hold  = 1;
        end
      end else if (m_phase == 1) begin
        if (l || !q[m_owner] || m_hold == MAXH) begin
          m_to    = (l || !q[m_owner]) ? 0 : 1;
          m_tok   = (m_owner + 1) % N;
          m_owner = -1;
          m_phase = 2;
          m_hold  = 0;
        end else begin
          m_hold = (m_hold + 1 > MAXH) ? MAXH : m_hold + 1;
        end
      end else begin
        m_phase = 0;
      end
    end
  endtask

  initial begin
    logic [N-1:0] rq;
    logic         rl;
    logic         rr;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_i = '0;
    bus.release_i = 1'b0;

    // Reset, single request, wrap and abandon.
    add(1, 4'b0000, 0, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0000, 0, 4'b0000, 4'b0001, 0, 0);
    add(0, 4'b0100, 0, 4'b0100, 4'b0001, 1, 0);
    add(0, 4'b0100, 1, 4'b0000, 4'b1000, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b1000, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b1000, 0, 0);
    add(0, 4'b0011, 0, 4'b0001, 4'b1000, 1, 0);
    add(0, 4'b0010, 0, 4'b0000, 4'b0010, 0, 0);
    add(0, 4'b0010, 0, 4'b0000, 4'b0010, 0, 0);
    add(0, 4'b0010, 0, 4'b0010, 4'b0010, 1, 0);
    add(0, 4'b0000, 1, 4'b0000, 4'b0100, 0, 0);
    // All requesting: 0,1,2,3,0 with a gap between owners.
    add(1, 4'b1111, 0, 4'b0000, 4'b0001, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0010, 0, 0);
    add(0, 4'b1111, 0, 4'b0000, 4'b0010, 0, 0);
    add(0, 4'b1111, 0, 4'b0010, 4'b0010, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0100, 0, 0);
    add(0, 4'b1111, 0, 4'b0000, 4'b0100, 0, 0);
    add(0, 4'b1111, 0, 4'b0100, 4'b0100, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b1000, 0, 0);
    add(0, 4'b1111, 0, 4'b0000, 4'b1000, 0, 0);
    add(0, 4'b1111, 0, 4'b1000, 4'b1000, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0001, 0, 0);
    add(0, 4'b1111, 0, 4'b0000, 4'b0001, 0, 0);
    add(0, 4'b1111, 0, 4'b0001, 4'b0001, 1, 0);
    add(0, 4'b1111, 1, 4'b0000, 4'b0010, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].req, tbl[i].rel);
      outs($sformatf("vec%0d", i), tbl[i].g, tbl[i].t, tbl[i].b, tbl[i].to);
    end

    // Hold limit: eight grant cycles, then a one-cycle timeout pulse.
    cyc(1, 4'b0010, 0);
    for (int k = 1; k <= MAXH; k++) begin
      cyc(0, 4'b0010, 0);
      outs($sformatf("hold%0d", k), 4'b0010, 4'b0001, 1, 0);
    end
    cyc(0, 4'b0010, 0);
    outs("timeout", 4'b0000, 4'b0100, 0, 1);
    cyc(0, 4'b0010, 0);
    outs("timeout_end", 4'b0000, 4'b0100, 0, 0);

    // Release coinciding with the limit is a normal end.
    for (int k = 1; k <= MAXH; k++) begin
      cyc(0, 4'b0010, 0);
      outs($sformatf("hold_b%0d", k), 4'b0010, 4'b0100, 1, 0);
    end
    cyc(0, 4'b0010, 1);
    outs("rel_at_limit", 4'b0000, 4'b0100, 0, 0);

    // Reset while granted drops the grant with no pulse.
    cyc(0, 4'b0001, 0);
    cyc(0, 4'b0001, 0);
    outs("pre_rst", 4'b0001, 4'b0100, 1, 0);
    cyc(1, 4'b0001, 0);
    outs("mid_rst", 4'b0000, 4'b0001, 0, 0);

    // Random traffic against the model.
    model_step(1, '0, 0);
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) rq = N'($urandom);
      rl = ($urandom_range(0, 9) == 0);
      rr = ($urandom_range(0, 299) == 0);
      cyc(rr, rq, rl);
      model_step(rr, rq, rl);
      outs("rand",
           (m_owner < 0) ? N'(0) : N'(1) << m_owner,
           N'(1) << m_tok,
           logic'(m_phase == 1),
           logic'(m_to));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
